// File: rtl/axi_wr_stream_sink.sv
// AXI4 write-channel slave that turns accepted write bursts into an AXI4-Stream.
// One AW is taken at a time, W beats are counted against awlen (no wlast upstream),
// beats are buffered in a first-word-fall-through FIFO, and one B is returned per burst.
module axi_wr_stream_sink #(
  parameter int unsigned AXI_ADDR   = 40,
  parameter int unsigned AXI_ID     = 16,
  parameter int unsigned AXI_LEN    = 8,
  parameter int unsigned AXI_DATA   = 128,
  parameter int unsigned AXI_STRB   = AXI_DATA / 8,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                s_axi_aclk,
  input  logic                s_axi_aresetn,
  // AW channel
  input  logic [AXI_ADDR-1:0] s_axi_awaddr,
  input  logic [AXI_ID-1:0]   s_axi_awid,
  input  logic [AXI_LEN-1:0]  s_axi_awlen,
  input  logic [2:0]          s_axi_awsize,
  input  logic [1:0]          s_axi_awburst,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  // W channel
  input  logic [AXI_DATA-1:0] s_axi_wdata,
  input  logic [AXI_STRB-1:0] s_axi_wstrb,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  // B channel
  output logic [1:0]          s_axi_bresp,
  output logic [AXI_ID-1:0]   s_axi_bid,
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready,
  // Stream output
  output logic [AXI_DATA-1:0] m_axis_tdata,
  output logic [AXI_STRB-1:0] m_axis_tkeep,
  output logic                m_axis_tlast,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  // Address of the most recently accepted burst
  output logic [AXI_ADDR-1:0] burst_addr
);

  localparam int unsigned IDX_W = $clog2(FIFO_DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;
  localparam int unsigned CNT_W = AXI_LEN + 1;
  localparam int unsigned ENT_W = AXI_DATA + AXI_STRB + 1;
  localparam logic [2:0]  FULL_SIZE  = 3'($clog2(AXI_STRB));
  localparam logic [1:0]  BURST_INCR = 2'b01;
  localparam logic [1:0]  RESP_OKAY  = 2'b00;
  localparam logic [1:0]  RESP_SLV   = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                awready_q, awready_d;
  logic [AXI_ID-1:0]   id_q, id_d;
  logic [AXI_LEN-1:0]  len_q, len_d;
  logic [AXI_ADDR-1:0] addr_q, addr_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic                bvalid_q, bvalid_d;
  logic [AXI_ID-1:0]   bid_q, bid_d;
  logic [1:0]          bresp_q, bresp_d;

  // FIFO state
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PTR_W-1:0]    count_c;
  logic                full_c;
  logic                empty_c;
  logic                push_c;
  logic                pop_c;
  logic                last_beat_c;
  logic                wready_c;
  logic [ENT_W-1:0]    mem_q [FIFO_DEPTH];
  logic [ENT_W-1:0]    head_c;

  assign count_c  = wr_ptr_q - rd_ptr_q;
  assign full_c   = (count_c == PTR_W'(FIFO_DEPTH));
  assign empty_c  = (count_c == '0);
  assign pop_c    = !empty_c && m_axis_tready;
  // W acceptance depends only on registered state and FIFO occupancy
  assign wready_c = (state_q == ST_DATA) && !full_c;

  // State register
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and burst bookkeeping
  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    len_d       = len_q;
    addr_d      = addr_q;
    err_d       = err_q;
    beat_cnt_d  = beat_cnt_q;
    bvalid_d    = bvalid_q;
    bid_d       = bid_q;
    bresp_d     = bresp_q;
    push_c      = 1'b0;
    last_beat_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (s_axi_awvalid && awready_q) begin
          state_d    = ST_DATA;
          id_d       = s_axi_awid;
          len_d      = s_axi_awlen;
          addr_d     = s_axi_awaddr;
          err_d      = (s_axi_awburst != BURST_INCR) || (s_axi_awsize != FULL_SIZE);
          beat_cnt_d = '0;
        end
      end
      ST_DATA: begin
        if (s_axi_wvalid && wready_c) begin
          last_beat_c = (beat_cnt_q == {1'b0, len_q});
          push_c      = !err_q;
          beat_cnt_d  = beat_cnt_q + CNT_W'(1);
          if (last_beat_c) begin
            state_d  = ST_RESP;
            bvalid_d = 1'b1;
            bid_d    = id_q;
            bresp_d  = err_q ? RESP_SLV : RESP_OKAY;
          end
        end
      end
      ST_RESP: begin
        if (s_axi_bready) begin
          state_d  = ST_IDLE;
          bvalid_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // awready mirrors the state we are about to be in, so it is high only in IDLE
    awready_d = (state_d == ST_IDLE);
  end

  // Burst capture, beat counter and B-channel registers
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      awready_q  <= 1'b0;
      id_q       <= '0;
      len_q      <= '0;
      addr_q     <= '0;
      err_q      <= 1'b0;
      beat_cnt_q <= '0;
      bvalid_q   <= 1'b0;
      bid_q      <= '0;
      bresp_q    <= '0;
    end else begin
      awready_q  <= awready_d;
      id_q       <= id_d;
      len_q      <= len_d;
      addr_q     <= addr_d;
      err_q      <= err_d;
      beat_cnt_q <= beat_cnt_d;
      bvalid_q   <= bvalid_d;
      bid_q      <= bid_d;
      bresp_q    <= bresp_d;
    end
  end

  // FIFO pointers; a push and pop in the same cycle keep the count unchanged
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_c) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset
  always_ff @(posedge s_axi_aclk) begin
    if (push_c) begin
      mem_q[wr_ptr_q[IDX_W-1:0]] <= {s_axi_wdata, s_axi_wstrb, last_beat_c};
    end
  end

  // Head entry is gated by tvalid so stream outputs read zero whenever empty
  assign head_c = empty_c ? '0 : mem_q[rd_ptr_q[IDX_W-1:0]];

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_c;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bid     = bid_q;
  assign s_axi_bresp   = bresp_q;
  assign m_axis_tvalid = !empty_c;
  assign m_axis_tdata  = head_c[ENT_W-1 -: AXI_DATA];
  assign m_axis_tkeep  = head_c[AXI_STRB:1];
  assign m_axis_tlast  = head_c[0];
  assign burst_addr    = addr_q;

endmodule

// File: tb/tb_axi_wr_stream_sink.sv
// Self-checking bench for axi_wr_stream_sink: a table of directed bursts, random
// bursts, and hand-written backpressure and reset sequences, all checked against
// a queue model of the expected stream.
`timescale 1ns/1ps
module tb_axi_wr_stream_sink;

  localparam int unsigned AXI_ADDR   = 40;
  localparam int unsigned AXI_ID     = 16;
  localparam int unsigned AXI_LEN    = 8;
  localparam int unsigned AXI_DATA   = 128;
  localparam int unsigned AXI_STRB   = 16;
  localparam int unsigned FIFO_DEPTH = 16;

  logic                clk = 1'b0;
  logic                aresetn;
  logic [AXI_ADDR-1:0] awaddr;
  logic [AXI_ID-1:0]   awid;
  logic [AXI_LEN-1:0]  awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;
  logic [AXI_DATA-1:0] wdata;
  logic [AXI_STRB-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic [AXI_ID-1:0]   bid;
  logic                bvalid;
  logic                bready;
  logic [AXI_DATA-1:0] tdata;
  logic [AXI_STRB-1:0] tkeep;
  logic                tlast;
  logic                tvalid;
  logic                tready;
  logic [AXI_ADDR-1:0] baddr;

  always #5 clk = ~clk;

  axi_wr_stream_sink #(
    .AXI_ADDR(AXI_ADDR), .AXI_ID(AXI_ID), .AXI_LEN(AXI_LEN),
    .AXI_DATA(AXI_DATA), .AXI_STRB(AXI_STRB), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .s_axi_aclk(clk), .s_axi_aresetn(aresetn),
    .s_axi_awaddr(awaddr), .s_axi_awid(awid), .s_axi_awlen(awlen),
    .s_axi_awsize(awsize), .s_axi_awburst(awburst),
    .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bid(bid),
    .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .m_axis_tdata(tdata), .m_axis_tkeep(tkeep), .m_axis_tlast(tlast),
    .m_axis_tvalid(tvalid), .m_axis_tready(tready),
    .burst_addr(baddr)
  );

  typedef struct {
    logic [AXI_DATA-1:0] data;
    logic [AXI_STRB-1:0] strb;
    logic                last;
  } beat_t;

  typedef struct {
    logic [15:0] id;
    logic [39:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    int          tready_pct;
    int          wgap;
    int          bstall;
    logic [1:0]  exp_resp;
  } vec_t;

  beat_t       exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          tready_pct = 100;
  logic        cur_err;
  logic [7:0]  cur_len;
  logic [15:0] cur_id;
  int          beat_idx;

  task automatic check(input string nm, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Random stream backpressure, updated just after each rising edge
  initial begin
    tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tready = (int'($urandom_range(0, 99)) < tready_pct);
    end
  end

  // Stream monitor: every beat leaving the DUT must match the model queue head
  always @(negedge clk) begin
    beat_t e;
    if (tvalid && tready) begin
      if (exp_q.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL stream_unexpected: got beat %0h expected none", tdata);
      end else begin
        e = exp_q.pop_front();
        check("tdata", 160'(tdata), 160'(e.data));
        check("tkeep", 160'(tkeep), 160'(e.strb));
        check("tlast", 160'(tlast), 160'(e.last));
      end
    end
  end

  task automatic aw_phase(input logic [15:0] id, input logic [39:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    int n;
    n        = 0;
    cur_err  = (burst != 2'b01) || (size != 3'd4);
    cur_len  = len;
    cur_id   = id;
    beat_idx = 0;
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst;
    awvalid = 1'b1;
    @(negedge clk);
    while (!awready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!awready) begin
      errors++;
      checks++;
      $display("FAIL aw_timeout: got awready 0 expected 1 within 200 cycles");
    end
    tick();
    awvalid = 1'b0;
    check("awready_drop", 160'(awready), 160'(0));
    check("burst_addr", 160'(baddr), 160'(addr));
  endtask

  task automatic w_beat(input int gap);
    int                  n;
    logic [AXI_DATA-1:0] d;
    logic [AXI_STRB-1:0] s;
    logic                was_empty;
    logic                last;
    n = 0;
    repeat (gap) tick();
    d = {$urandom, $urandom, $urandom, $urandom};
    s = 16'($urandom);
    wdata = d; wstrb = s; wvalid = 1'b1;
    @(negedge clk);
    while (!wready && n < 5000) begin
      n++;
      @(negedge clk);
    end
    if (!wready) begin
      errors++;
      checks++;
      $display("FAIL w_timeout: got wready 0 expected 1 within 5000 cycles");
      tick();
      wvalid = 1'b0;
      return;
    end
    was_empty = (exp_q.size() == 0);
    last      = (beat_idx == int'(cur_len));
    if (!cur_err) exp_q.push_back('{d, s, last});
    beat_idx++;
    tick();
    wvalid = 1'b0;
    if (!cur_err && was_empty) begin
      check("latency_tvalid", 160'(tvalid), 160'(1));
      check("latency_tdata", 160'(tdata), 160'(d));
    end
  endtask

  task automatic b_phase(input int stall, input logic [1:0] exp_resp);
    int n;
    n = 0;
    check("bvalid", 160'(bvalid), 160'(1));
    check("bid", 160'(bid), 160'(cur_id));
    check("bresp", 160'(bresp), 160'(exp_resp));
    check("wready_in_resp", 160'(wready), 160'(0));
    bready = 1'b0;
    repeat (stall) begin
      tick();
      check("bvalid_hold", 160'(bvalid), 160'(1));
      check("bid_hold", 160'(bid), 160'(cur_id));
      check("bresp_hold", 160'(bresp), 160'(exp_resp));
      check("awready_stall", 160'(awready), 160'(0));
    end
    bready = 1'b1;
    @(negedge clk);
    tick();
    bready = 1'b0;
    check("bvalid_clear", 160'(bvalid), 160'(0));
    check("awready_back", 160'(awready), 160'(1));
  endtask

  task automatic drain();
    int n;
    n = 0;
    tready_pct = 100;
    while (exp_q.size() > 0 && n < 2000) begin
      n++;
      tick();
    end
    if (exp_q.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain_timeout: got %0d beats pending expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) tick();
    check("tvalid_idle", 160'(tvalid), 160'(0));
  endtask

  task automatic run_burst(input vec_t v);
    tready_pct = v.tready_pct;
    aw_phase(v.id, v.addr, v.len, v.size, v.burst);
    for (int b = 0; b <= int'(v.len); b++) w_beat(v.wgap == 0 ? 0 : int'($urandom_range(0, v.wgap)));
    b_phase(v.bstall, v.exp_resp);
    drain();
  endtask

  vec_t vecs[8];

  initial begin
    vec_t rv;

    // id, addr, len, size, burst, tready%, wgap, bstall, bresp
    vecs[0] = '{16'h00A5, 40'h12_3456_7890, 8'd3,   3'd4, 2'b01, 100, 0, 0,  2'b00};
    vecs[1] = '{16'h0011, 40'h00_0000_1000, 8'd1,   3'd4, 2'b10, 100, 0, 0,  2'b10};
    vecs[2] = '{16'h0022, 40'h00_0000_2000, 8'd2,   3'd3, 2'b01, 100, 1, 0,  2'b10};
    vecs[3] = '{16'h0033, 40'h00_0000_3000, 8'd0,   3'd4, 2'b00, 100, 0, 0,  2'b10};
    vecs[4] = '{16'h0044, 40'hFF_FFFF_FFF0, 8'd0,   3'd4, 2'b01, 100, 0, 0,  2'b00};
    vecs[5] = '{16'hBEEF, 40'h00_0000_5000, 8'd7,   3'd4, 2'b01, 50,  2, 1,  2'b00};
    vecs[6] = '{16'h7777, 40'h00_0000_6000, 8'd2,   3'd4, 2'b01, 100, 0, 10, 2'b00};
    vecs[7] = '{16'hFFFF, 40'h00_0000_7000, 8'd255, 3'd4, 2'b01, 100, 0, 0,  2'b00};

    aresetn = 1'b0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
    awaddr = '0; awid = '0; awlen = '0; awsize = '0; awburst = '0;
    wdata = '0; wstrb = '0;
    #1;
    check("rst_awready", 160'(awready), 160'(0));
    check("rst_wready", 160'(wready), 160'(0));
    check("rst_bvalid", 160'(bvalid), 160'(0));
    check("rst_tvalid", 160'(tvalid), 160'(0));
    check("rst_tdata", 160'(tdata), 160'(0));
    check("rst_burst_addr", 160'(baddr), 160'(0));
    repeat (3) @(negedge clk);
    aresetn = 1'b1;
    tick();
    check("awready_after_rst", 160'(awready), 160'(1));

    // Directed table
    for (int i = 0; i < 8; i++) run_burst(vecs[i]);

    // Backpressure: FIFO fills after 16 beats of a 20-beat burst
    tready_pct = 0;
    repeat (2) tick();
    aw_phase(16'h0BAD, 40'h00_0000_8000, 8'd19, 3'd4, 2'b01);
    for (int b = 0; b < 16; b++) w_beat(0);
    check("wready_full", 160'(wready), 160'(0));
    repeat (3) begin
      tick();
      check("wready_full_hold", 160'(wready), 160'(0));
      check("tvalid_full", 160'(tvalid), 160'(1));
    end
    tready_pct = 100;
    for (int b = 16; b < 20; b++) w_beat(0);
    b_phase(0, 2'b00);
    drain();

    // Random bursts against the model
    for (int i = 0; i < 20; i++) begin
      rv.id         = 16'($urandom);
      rv.addr       = {8'($urandom), 32'($urandom)};
      rv.len        = 8'($urandom_range(0, 15));
      rv.size       = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'd4;
      rv.burst      = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b01;
      rv.tready_pct = int'($urandom_range(20, 100));
      rv.wgap       = int'($urandom_range(0, 2));
      rv.bstall     = int'($urandom_range(0, 3));
      rv.exp_resp   = ((rv.burst != 2'b01) || (rv.size != 3'd4)) ? 2'b10 : 2'b00;
      run_burst(rv);
    end

    // Reset mid-burst with beats still sitting in the FIFO
    tready_pct = 0;
    repeat (2) tick();
    aw_phase(16'h0123, 40'h00_0000_9000, 8'd7, 3'd4, 2'b01);
    w_beat(0);
    w_beat(0);
    check("pre_rst_tvalid", 160'(tvalid), 160'(1));
    #2;
    aresetn = 1'b0;
    #1;
    check("mid_rst_tvalid", 160'(tvalid), 160'(0));
    check("mid_rst_tdata", 160'(tdata), 160'(0));
    check("mid_rst_tkeep", 160'(tkeep), 160'(0));
    check("mid_rst_tlast", 160'(tlast), 160'(0));
    check("mid_rst_wready", 160'(wready), 160'(0));
    check("mid_rst_awready", 160'(awready), 160'(0));
    check("mid_rst_bvalid", 160'(bvalid), 160'(0));
    check("mid_rst_bid", 160'(bid), 160'(0));
    check("mid_rst_bresp", 160'(bresp), 160'(0));
    check("mid_rst_burst_addr", 160'(baddr), 160'(0));
    exp_q.delete();
    repeat (2) @(negedge clk);
    aresetn = 1'b1;
    tick();
    check("awready_after_mid_rst", 160'(awready), 160'(1));
    run_burst('{16'h0456, 40'h00_0000_A000, 8'd5, 3'd4, 2'b01, 100, 0, 0, 2'b00});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the bench always terminates
  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish before 2ms");
    $fatal(1, "watchdog expired");
  end

endmodule
